// File: rtl/risc_pkg.sv
// Shared decode definitions: instruction field positions, two-word opcode class and decode FSM states.
package risc_pkg;

   localparam int DATA_W    = 16;
   localparam int NREGS     = 8;
   localparam int REG_IDX_W = 3;
   localparam int INSTR_W   = 16;
   localparam int OPC_W     = 5;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 11;
   localparam int RD_MSB  = 10;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 5;
   localparam int RS2_MSB = 4;
   localparam int RS2_LSB = 2;

   // Opcodes whose top two bits match this class carry a trailing immediate word.
   localparam logic [1:0] OPC_IMM_CLASS = 2'b11;

   typedef enum logic {
      FIRST    = 1'b0,
      WAIT_IMM = 1'b1
   } dec_state_e;

   function automatic logic is_two_word(input logic [1:0] opc_class);
      return opc_class == OPC_IMM_CLASS;
   endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: NREGS x DATA_W, two asynchronous read ports, one synchronous write port.
module register_file
   import risc_pkg::*;
#(
   parameter int W     = DATA_W,
   parameter int N     = NREGS,
   parameter int IDX_W = REG_IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_addr_i,
   input  logic [W-1:0]     wr_data_i,
   input  logic [IDX_W-1:0] rd_addr_a_i,
   input  logic [IDX_W-1:0] rd_addr_b_i,
   output logic [W-1:0]     rd_data_a_o,
   output logic [W-1:0]     rd_data_b_o
);

   logic [W-1:0] regs_q [N];

   // One register per entry so each has its own reset and write decode; R0 is an ordinary register.
   for (genvar gi = 0; gi < N; gi++) begin : g_reg
      always_ff @(posedge clk) begin
         if (reset) begin
            regs_q[gi] <= '0;
         end else if (wr_en_i && (wr_addr_i == IDX_W'(gi))) begin
            regs_q[gi] <= wr_data_i;
         end
      end
   end

   assign rd_data_a_o = regs_q[rd_addr_a_i];
   assign rd_data_b_o = regs_q[rd_addr_b_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: assembles one/two-word instructions, reads operands and registers the bundle for execute.
// Optional DECODE_WB_BYPASS_EN forwards a same-cycle writeback into the operand reads.
module decode_stage
   import risc_pkg::*;
#(
   parameter int DATA_W = risc_pkg::DATA_W,
   parameter int NREGS  = risc_pkg::NREGS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   instruction,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 wb_en,
   input  logic [REG_IDX_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]    wb_data,
   output logic                 out_valid,
   output logic [OPC_W-1:0]     out_opcode,
   output logic [REG_IDX_W-1:0] out_rd,
   output logic [DATA_W-1:0]    out_rs1_data,
   output logic [DATA_W-1:0]    out_rs2_data,
   output logic [DATA_W-1:0]    out_imm
);

   dec_state_e           state_q, state_d;
   logic [INSTR_W-1:0]   hold_q, hold_d;
   logic                 valid_q, valid_d;
   logic [OPC_W-1:0]     opcode_q, opcode_d;
   logic [REG_IDX_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0]    rs1_q, rs1_d;
   logic [DATA_W-1:0]    rs2_q, rs2_d;
   logic [DATA_W-1:0]    imm_q, imm_d;

   logic                 accept;
   logic [OPC_W-1:0]     sel_opcode;
   logic [REG_IDX_W-1:0] sel_rd, sel_rs1, sel_rs2;
   logic [DATA_W-1:0]    rf_rs1, rf_rs2, op_rs1, op_rs2;

   assign in_ready = !stall && !reset;
   assign accept   = in_valid && in_ready;

   // While waiting for the immediate, the fields come from the held first word.
   always_comb begin
      if (state_q == WAIT_IMM) begin
         sel_opcode = hold_q[OPC_MSB:OPC_LSB];
         sel_rd     = hold_q[RD_MSB:RD_LSB];
         sel_rs1    = hold_q[RS1_MSB:RS1_LSB];
         sel_rs2    = hold_q[RS2_MSB:RS2_LSB];
      end else begin
         sel_opcode = instruction[OPC_MSB:OPC_LSB];
         sel_rd     = instruction[RD_MSB:RD_LSB];
         sel_rs1    = instruction[RS1_MSB:RS1_LSB];
         sel_rs2    = instruction[RS2_MSB:RS2_LSB];
      end
   end

   register_file #(
      .W     (DATA_W),
      .N     (NREGS),
      .IDX_W (REG_IDX_W)
   ) u_rf (
      .clk         (clk),
      .reset       (reset),
      .wr_en_i     (wb_en),
      .wr_addr_i   (wb_addr),
      .wr_data_i   (wb_data),
      .rd_addr_a_i (sel_rs1),
      .rd_addr_b_i (sel_rs2),
      .rd_data_a_o (rf_rs1),
      .rd_data_b_o (rf_rs2)
   );

`ifdef DECODE_WB_BYPASS_EN
   assign op_rs1 = (wb_en && (wb_addr == sel_rs1)) ? wb_data : rf_rs1;
   assign op_rs2 = (wb_en && (wb_addr == sel_rs2)) ? wb_data : rf_rs2;
`else
   assign op_rs1 = rf_rs1;
   assign op_rs2 = rf_rs2;
`endif

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      valid_d  = valid_q;
      opcode_d = opcode_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_d    = imm_q;

      if (flush) begin
         valid_d = 1'b0;
         state_d = FIRST;
         hold_d  = '0;
      end else if (!stall) begin
         valid_d = 1'b0;
         if (accept) begin
            if ((state_q == FIRST) && is_two_word(instruction[OPC_MSB -: 2])) begin
               hold_d  = instruction;
               state_d = WAIT_IMM;
            end else begin
               valid_d  = 1'b1;
               opcode_d = sel_opcode;
               rd_d     = sel_rd;
               rs1_d    = op_rs1;
               rs2_d    = op_rs2;
               imm_d    = (state_q == WAIT_IMM) ? DATA_W'(instruction) : '0;
               state_d  = FIRST;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FIRST;
         hold_q   <= '0;
         valid_q  <= 1'b0;
         opcode_q <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         valid_q  <= valid_d;
         opcode_q <= opcode_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_opcode   = opcode_q;
   assign out_rd       = rd_q;
   assign out_rs1_data = rs1_q;
   assign out_rs2_data = rs2_q;
   assign out_imm      = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a per-edge reference model queues the expected outputs, a monitor checks them.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] instruction;
   logic        stall;
   logic        flush;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        out_valid;
   logic [4:0]  out_opcode;
   logic [2:0]  out_rd;
   logic [15:0] out_rs1_data;
   logic [15:0] out_rs2_data;
   logic [15:0] out_imm;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .instruction  (instruction),
      .stall        (stall),
      .flush        (flush),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .out_valid    (out_valid),
      .out_opcode   (out_opcode),
      .out_rd       (out_rd),
      .out_rs1_data (out_rs1_data),
      .out_rs2_data (out_rs2_data),
      .out_imm      (out_imm)
   );

   typedef struct {
      bit        rst;
      bit        valid;
      bit [4:0]  opc;
      bit [2:0]  rd;
      bit [15:0] r1;
      bit [15:0] r2;
      bit [15:0] imm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: architectural registers and an optional pending first word.
   bit [15:0] m_regs [8];
   bit        m_pend;
   bit [15:0] m_first;
   exp_t      m_last;
   exp_t      m_e;
   bit [15:0] m_word;

   function automatic bit [15:0] model_read(input bit [2:0] idx);
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && wb_addr == idx) return wb_data;
`endif
      return m_regs[idx];
   endfunction

   always @(posedge clk) begin
      m_e = '{default: 0};
      if (reset) begin
         m_e.rst = 1'b1;
         for (int i = 0; i < 8; i++) m_regs[i] = '0;
         m_pend = 1'b0;
      end else begin
         if (flush) begin
            m_pend = 1'b0;
         end else if (stall) begin
            m_e = m_last;
         end else if (in_valid) begin
            if (!m_pend && instruction[15:14] == 2'b11) begin
               m_pend  = 1'b1;
               m_first = instruction;
            end else begin
               m_word  = m_pend ? m_first : instruction;
               m_e.valid = 1'b1;
               m_e.opc   = m_word[15:11];
               m_e.rd    = m_word[10:8];
               m_e.r1    = model_read(m_word[7:5]);
               m_e.r2    = model_read(m_word[4:2]);
               m_e.imm   = m_pend ? instruction : 16'h0;
               m_pend    = 1'b0;
            end
         end
         if (wb_en) m_regs[wb_addr] = wb_data;
      end
      m_last = m_e;
      exp_q.push_back(m_e);
   end

   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (in_ready !== (!stall && !reset)) begin
         errors++;
         $display("FAIL in_ready: got %0b want %0b at %0t", in_ready, !stall && !reset, $time);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (out_valid !== e.valid) begin
            errors++;
            $display("FAIL out_valid: got %0b want %0b at %0t", out_valid, e.valid, $time);
         end
         if (e.valid || e.rst) begin
            checks++;
            if ({out_opcode, out_rd, out_rs1_data, out_rs2_data, out_imm} !==
                {e.opc, e.rd, e.r1, e.r2, e.imm}) begin
               errors++;
               $display("FAIL bundle: got opc=%h rd=%0d rs1=%h rs2=%h imm=%h want opc=%h rd=%0d rs1=%h rs2=%h imm=%h at %0t",
                        out_opcode, out_rd, out_rs1_data, out_rs2_data, out_imm,
                        e.opc, e.rd, e.r1, e.r2, e.imm, $time);
            end
         end
      end
   end

   task automatic drive(input bit v, input bit [15:0] ins, input bit st, input bit fl,
                        input bit we, input bit [2:0] wa, input bit [15:0] wd);
      in_valid    = v;
      instruction = ins;
      stall       = st;
      flush       = fl;
      wb_en       = we;
      wb_addr     = wa;
      wb_data     = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 16'h0, 0, 0, 0, 3'd0, 16'h0);
   endtask

   initial begin
      bit [15:0] ins;
      reset = 1'b1;
      drive(0, 16'h0, 0, 0, 0, 3'd0, 16'h0);
      drive(0, 16'h0, 0, 0, 0, 3'd0, 16'h0);
      reset = 1'b0;
      idle();

      drive(0, 16'h0000, 0, 0, 1, 3'd3, 16'h00AA);      // R3 = 0x00AA
      drive(1, 16'h0B60, 0, 0, 0, 3'd0, 16'h0);         // one-word op reading R3
      idle();
      drive(1, 16'hF900, 0, 0, 0, 3'd0, 16'h0);         // two-word op
      drive(1, 16'h1234, 0, 0, 0, 3'd0, 16'h0);
      idle();
      drive(1, 16'hF900, 0, 0, 0, 3'd0, 16'h0);         // flushed before immediate
      drive(1, 16'h1234, 0, 1, 0, 3'd0, 16'h0);
      drive(1, 16'h0B60, 0, 0, 0, 3'd0, 16'h0);
      idle();
      drive(1, 16'h0B60, 0, 0, 0, 3'd0, 16'h0);         // stall with a valid bundle
      for (int i = 0; i < 3; i++) drive(1, 16'h0B60, 1, 0, 1, 3'd5, 16'hBEEF);
      drive(1, 16'h08A0, 0, 0, 0, 3'd0, 16'h0);         // reads R5
      drive(1, 16'h0B60, 0, 0, 1, 3'd3, 16'h5555);      // same-cycle wb to R3
      idle();
      drive(1, 16'hF900, 0, 0, 0, 3'd0, 16'h0);         // flush during stall
      drive(1, 16'h1234, 1, 1, 0, 3'd0, 16'h0);
      drive(1, 16'h0B60, 0, 0, 0, 3'd0, 16'h0);
      drive(1, 16'hF900, 0, 0, 1, 3'd7, 16'h7777);      // reset mid two-word op
      reset = 1'b1;
      drive(1, 16'h1234, 0, 0, 0, 3'd0, 16'h0);
      reset = 1'b0;
      drive(1, 16'h0B60, 0, 0, 0, 3'd0, 16'h0);
      idle();

      for (int n = 0; n < 3000; n++) begin
         ins = 16'($urandom);
         if ($urandom_range(3) == 0) ins[15:14] = 2'b11;
         reset = ($urandom_range(99) == 0);
         drive($urandom_range(1), ins, $urandom_range(99) < 15, $urandom_range(99) < 8,
               $urandom_range(1), 3'($urandom_range(7)), 16'($urandom));
      end
      reset = 1'b0;
      idle();
      idle();
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d queued want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
